dcache_responder: RTL and testbench

// Direct-mapped, write-through, no-write-allocate data cache between the ME stage
// and backing RAM. Responder to the CPU's load/store requests; initiator on the

---
 rtl/dcache_responder.sv | 168 ++++++++++++++++
 tb/tb_dcache_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache between the ME stage and RAM.
// Hits answer combinationally; a miss refills the whole line in word order, and each store drains to memory.
module dcache_responder #(
    parameter int INDEX_BITS = 4,
    parameter int OFFS_BITS  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int TAG_BITS = 32 - INDEX_BITS - OFFS_BITS - 2;
    localparam int LINES    = 2 ** INDEX_BITS;
    localparam int WORDS    = 2 ** (INDEX_BITS + OFFS_BITS);

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RDONE, S_WRITE} state_e;

    state_e               state_q, state_d;
    logic [OFFS_BITS-1:0] cnt_q, cnt_d;
    logic                 retire_q, retire_d;
    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [31:0]          data_q [WORDS];

    logic [TAG_BITS-1:0]   addr_tag;
    logic [INDEX_BITS-1:0] addr_idx;
    logic [OFFS_BITS-1:0]  addr_off;
    logic                  unused_byte_bits;

    assign addr_tag         = cpu_addr[31 -: TAG_BITS];
    assign addr_idx         = cpu_addr[OFFS_BITS+2 +: INDEX_BITS];
    assign addr_off         = cpu_addr[2 +: OFFS_BITS];
    assign unused_byte_bits = ^cpu_addr[1:0];

    logic        hit;
    logic [31:0] word_rd;
    logic        valid_clr, valid_set, refill_we, store_merge;

    assign hit     = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign word_rd = data_q[{addr_idx, addr_off}];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        retire_d    = 1'b0;
        valid_clr   = 1'b0;
        valid_set   = 1'b0;
        refill_we   = 1'b0;
        store_merge = 1'b0;
        cpu_rdata   = '0;
        cpu_stall   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;

        unique case (state_q)
            S_IDLE: begin
                // retire_q marks the cycle in which a just-drained store is released.
                if (cpu_req && !retire_q) begin
                    if (cpu_we) begin
                        cpu_stall   = 1'b1;
                        store_merge = hit;
                        state_d     = S_WRITE;
                    end else if (hit) begin
                        cpu_rdata = word_rd;
                    end else begin
                        cpu_stall = 1'b1;
                        valid_clr = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {addr_tag, addr_idx, cnt_q, 2'b00};
                if (mem_ack) begin
                    refill_we = 1'b1;
                    cnt_d     = cnt_q + OFFS_BITS'(1);
                    if (cnt_q == '1) begin
                        valid_set = 1'b1;
                        state_d   = S_RDONE;
                    end
                end
            end
            S_RDONE: begin
                cpu_rdata = word_rd;
                state_d   = S_IDLE;
            end
            S_WRITE: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {cpu_addr[31:2], 2'b00};
                mem_wdata = cpu_wdata;
                mem_wstrb = cpu_wstrb;
                if (mem_ack) begin
                    retire_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs read as idle for the whole time reset is held, even with a request pending.
        if (!rst) begin
            cpu_rdata = '0;
            cpu_stall = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            mem_wstrb = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            retire_q <= 1'b0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retire_q <= retire_d;
            if (valid_clr) begin
                valid_q[addr_idx] <= 1'b0;
            end else if (valid_set) begin
                valid_q[addr_idx] <= 1'b1;
            end
        end
    end

    // NOTE: tag and data arrays have no reset; valid_q alone decides whether their contents count.
    always_ff @(posedge clk) begin
        if (refill_we) begin
            data_q[{addr_idx, cnt_q}] <= mem_rdata;
        end
        if (valid_set) begin
            tag_q[addr_idx] <= addr_tag;
        end
        if (store_merge) begin
            for (int b = 0; b < 4; b++) begin
                if (cpu_wstrb[b]) begin
                    data_q[{addr_idx, addr_off}][8*b +: 8] <= cpu_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: a table of CPU accesses checked against a memory-side scoreboard,
// then hand-written sequences for spurious acks, a request dropped mid-store and reset mid-refill.
module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack, model_ack, spur_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;
    assign mem_ack = model_ack | spur_ack;

    dcache_responder dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wstrb(cpu_wstrb),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } memop_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        miss;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int LAT          = 2;              // idle cycles before the ack cycle
    localparam int WORD_CYCLES  = LAT + 1;
    localparam int MISS_STALLS  = 1 + 4 * WORD_CYCLES;
    localparam int STORE_STALLS = 1 + WORD_CYCLES;

    memop_t      exp_mem[$];
    logic [31:0] ram [logic [31:0]];
    vec_t        vecs [15];
    int          n_checks = 0;
    int          n_pass = 0;
    int          ack_count = 0;
    int          req_cycles = 0;
    int          wait_cnt = 0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : pat(a);
    endfunction

    function automatic vec_t mkv(input logic we, input logic [31:0] addr, wdata,
                                 input logic [3:0] strb, input logic miss, input logic [31:0] exp_rdata);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.strb = strb; v.miss = miss; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push_refill(input logic [31:0] addr);
        memop_t op;
        for (int w = 0; w < 4; w++) begin
            op.we = 1'b0; op.addr = {addr[31:4], 4'h0} + 32'(4 * w); op.wdata = '0; op.strb = '0;
            exp_mem.push_back(op);
        end
    endtask

    task automatic push_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        memop_t op;
        op.we = 1'b1; op.addr = {addr[31:2], 2'b00}; op.wdata = wdata; op.strb = strb;
        exp_mem.push_back(op);
    endtask

    // Memory model: acks on the third cycle a request is held, and checks each completed access.
    always @(negedge clk) begin
        if (!rst) begin
            model_ack = 1'b0;
            wait_cnt  = 0;
        end else begin
            if (mem_req) req_cycles++;
            if (model_ack) begin
                model_ack = 1'b0;
                wait_cnt  = 0;
            end
            if (mem_req) begin
                if (wait_cnt == LAT) begin
                    memop_t e;
                    logic [31:0] w;
                    model_ack = 1'b1;
                    ack_count++;
                    if (mem_we) begin
                        w = ram_rd(mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                        ram[mem_addr] = w;
                    end else begin
                        mem_rdata = ram_rd(mem_addr);
                    end
                    if (exp_mem.size() == 0) begin
                        check("mem_unexpected_access", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_mem.pop_front();
                        check("mem_we", 32'(mem_we), 32'(e.we));
                        check("mem_addr", mem_addr, e.addr);
                        check("mem_wdata", mem_wdata, e.wdata);
                        check("mem_wstrb", 32'(mem_wstrb), 32'(e.strb));
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Present one access and hold it until the cache releases the pipeline.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata, output int stalls);
        bit done = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = strb;
        stalls = 0;
        rdata = 'x;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                done  = 1'b1;
                rdata = cpu_rdata;
            end else begin
                stalls++;
            end
        end
        check("access_completes", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        int          st, rc0, a0;

        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          st, rc0, a0, exp_req;

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        spur_ack = 1'b0; model_ack = 1'b0; mem_rdata = '0;

        vecs[0]  = mkv(0, 32'h040, 32'h0,          4'h0,    1, pat(32'h040));
        vecs[1]  = mkv(0, 32'h048, 32'h0,          4'h0,    0, pat(32'h048));
        vecs[2]  = mkv(0, 32'h04A, 32'h0,          4'h0,    0, pat(32'h048));
        vecs[3]  = mkv(1, 32'h044, 32'h00EE_0000,  4'b0100, 0, 32'h0);
        vecs[4]  = mkv(0, 32'h044, 32'h0,          4'h0,    0, 32'hA0EE_0044);
        vecs[5]  = mkv(1, 32'h400, 32'h1234_5678,  4'b1111, 0, 32'h0);
        vecs[6]  = mkv(0, 32'h400, 32'h0,          4'h0,    1, 32'h1234_5678);
        vecs[7]  = mkv(0, 32'h44C, 32'h0,          4'h0,    1, pat(32'h44C));
        vecs[8]  = mkv(0, 32'h040, 32'h0,          4'h0,    1, pat(32'h040));
        vecs[9]  = mkv(0, 32'h044, 32'h0,          4'h0,    0, 32'hA0EE_0044);
        vecs[10] = mkv(1, 32'h40C, 32'hBEEF_0000,  4'b1100, 0, 32'h0);
        vecs[11] = mkv(0, 32'h40C, 32'h0,          4'h0,    0, 32'hBEEF_040C);
        vecs[12] = mkv(0, 32'h404, 32'h0,          4'h0,    0, pat(32'h404));
        vecs[13] = mkv(1, 32'h840, 32'h5555_5555,  4'b1111, 0, 32'h0);
        vecs[14] = mkv(0, 32'h040, 32'h0,          4'h0,    0, pat(32'h040));

        #1 rst = 1'b0;
        #1;
        check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        cpu_req = 1'b1; cpu_addr = 32'h40;
        #1;
        check("rst_stall_with_req", 32'(cpu_stall), 32'd0);
        check("rst_mem_req_with_req", 32'(mem_req), 32'd0);
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            rc0 = req_cycles;
            if (vecs[i].we) push_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            else if (vecs[i].miss) push_refill(vecs[i].addr);
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, st);
            exp_req = vecs[i].we ? WORD_CYCLES : (vecs[i].miss ? 4 * WORD_CYCLES : 0);
            if (!vecs[i].we) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_stalls", i), 32'(st),
                  32'(vecs[i].we ? STORE_STALLS : (vecs[i].miss ? MISS_STALLS : 0)));
            check($sformatf("v%0d_mem_req_cycles", i), 32'(req_cycles - rc0), 32'(exp_req));
            check($sformatf("v%0d_scoreboard_drained", i), 32'(exp_mem.size()), 32'd0);
        end

        // A stray ack while idle must not disturb a resident line.
        cpu_req = 1'b0; spur_ack = 1'b1;
        @(posedge clk);
        #1 spur_ack = 1'b0;
        rc0 = req_cycles;
        access(0, 32'h048, 32'h0, 4'h0, rd, st);
        check("spur_ack_rdata", rd, pat(32'h048));
        check("spur_ack_stalls", 32'(st), 32'd0);
        check("spur_ack_no_mem", 32'(req_cycles - rc0), 32'd0);

        // Request dropped mid-store: the write still drains and merges into the line.
        push_write(32'h048, 32'h0000_00AB, 4'b0001);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h048; cpu_wdata = 32'h0000_00AB; cpu_wstrb = 4'b0001;
        a0 = ack_count;
        for (int c = 0; c < 50 && !mem_req; c++) @(negedge clk);
        cpu_req = 1'b0;
        for (int c = 0; c < 50 && ack_count == a0; c++) @(negedge clk);
        check("drop_write_acks", 32'(ack_count - a0), 32'd1);
        @(negedge clk);
        check("drop_write_released", 32'(cpu_stall), 32'd0);
        check("drop_write_drained", 32'(exp_mem.size()), 32'd0);
        @(posedge clk);
        #1;
        access(0, 32'h048, 32'h0, 4'h0, rd, st);
        check("drop_write_merged", rd, 32'hA000_00AB);
        check("drop_write_hit_stalls", 32'(st), 32'd0);

        // Reset in the middle of a refill, then the same load refills from scratch.
        push_refill(32'h440);
        access(0, 32'h440, 32'h0, 4'h0, rd, st);
        check("evict_rdata", rd, pat(32'h440));
        push_refill(32'h040);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h040;
        a0 = ack_count;
        for (int c = 0; c < 100 && ack_count < a0 + 2; c++) @(posedge clk);
        check("midrefill_acks", 32'(ack_count - a0), 32'd2);
        #1 rst = 1'b0;
        #1;
        check("midrefill_rst_mem_req", 32'(mem_req), 32'd0);
        check("midrefill_rst_mem_addr", mem_addr, 32'h0);
        check("midrefill_rst_stall", 32'(cpu_stall), 32'd0);
        check("midrefill_rst_rdata", cpu_rdata, 32'h0);
        check("midrefill_pending_words", 32'(exp_mem.size()), 32'd2);
        exp_mem.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        push_refill(32'h040);
        access(0, 32'h040, 32'h0, 4'h0, rd, st);
        check("after_rst_rdata", rd, pat(32'h040));
        check("after_rst_stalls", 32'(st), 32'(MISS_STALLS));
        check("after_rst_drained", 32'(exp_mem.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
